// File: rtl/darkquad_run_pkg.sv
// Shared definitions for the darkquad run sequencer: FSM state encoding and
// field positions within the software run control word.
package darkquad_run_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StWaitPps = 3'd1,
      StHoldoff = 3'd2,
      StRun     = 3'd3,
      StFlush   = 3'd4
   } run_state_e;

   localparam int unsigned RUN_BIT  = 0;
   localparam int unsigned PPS_BIT  = 1;
   localparam int unsigned HOLD_LSB = 16;
   localparam int unsigned HOLD_MSB = 31;

endpackage

// File: rtl/darkquad_rise_det.sv
// Registered rising-edge detector: two flops in series, rise_o is high for
// the one cycle where the newer sample is 1 and the older sample is 0.
module darkquad_rise_det (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic rise_o
);

   logic p0_q;
   logic p1_q;

   // Sample the input twice so the edge is seen one cycle after it arrives.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         p0_q <= 1'b0;
         p1_q <= 1'b0;
      end else begin
         p0_q <= d_i;
         p1_q <= p0_q;
      end
   end

   assign rise_o = p0_q & ~p1_q;

endmodule

// File: rtl/darkquad_run_sequencer.sv
// Turns the level-based software run register into a sequenced run window
// with optional 1PPS alignment, holdoff, start/stop/timestamp-reset strobes,
// a post-stop flush, and run-time / run-count status.
module darkquad_run_sequencer
   import darkquad_run_pkg::*;
#(
   parameter int unsigned C_TIME_W       = 32,
   parameter int unsigned C_FLUSH_CYCLES = 256,
   parameter int unsigned C_PPS_TIMEOUT  = 300000000
) (
   input  logic                user_clk,
   input  logic                user_rst_n,
   input  logic [31:0]         run_reg_in,
   input  logic                pps_in,
   output logic                run_en,
   output logic                start_pulse,
   output logic                stop_pulse,
   output logic                ts_rst,
   output logic [C_TIME_W-1:0] run_time,
   output logic [15:0]         run_count,
   output logic [2:0]          state_out,
   output logic                err_pps_timeout
);

   localparam int unsigned TmoW   = (C_PPS_TIMEOUT > 1) ? $clog2(C_PPS_TIMEOUT) : 1;
   localparam int unsigned FlushW = (C_FLUSH_CYCLES > 1) ? $clog2(C_FLUSH_CYCLES) : 1;
   localparam logic [TmoW-1:0]   TmoLast   = TmoW'(C_PPS_TIMEOUT - 1);
   localparam logic [FlushW-1:0] FlushLast = FlushW'(C_FLUSH_CYCLES - 1);

   run_state_e          state_q;
   logic [31:0]         r_reg_q;
   logic                rearm_q;
   logic [15:0]         hold_cnt_q;
   logic [TmoW-1:0]     tmo_cnt_q;
   logic [FlushW-1:0]   flush_cnt_q;
   logic                run_en_q;
   logic                start_pulse_q;
   logic                stop_pulse_q;
   logic                ts_rst_q;
   logic [C_TIME_W-1:0] run_time_q;
   logic [C_TIME_W-1:0] run_time_d;
   logic [15:0]         run_count_q;
   logic                err_q;
   logic                pps_rise;
   logic                run_bit;
   logic                unused_reg_bits;

   darkquad_rise_det u_pps_rise (
      .clk_i  (user_clk),
      .rst_ni (user_rst_n),
      .d_i    (pps_in),
      .rise_o (pps_rise)
   );

   // Single register stage on the control word.
   always_ff @(posedge user_clk) begin
      if (!user_rst_n) begin
         r_reg_q <= '0;
      end else begin
         r_reg_q <= run_reg_in;
      end
   end

   assign run_bit         = r_reg_q[RUN_BIT];
   assign unused_reg_bits = ^r_reg_q[HOLD_LSB-1:PPS_BIT+1];

   // Saturating increment of the run timer.
   always_comb begin
      run_time_d = run_time_q;
      if (!(&run_time_q)) begin
         run_time_d = run_time_q + 1'b1;
      end
   end

   // Sequencer FSM with registered strobes, counters and status.
   always_ff @(posedge user_clk) begin
      if (!user_rst_n) begin
         state_q       <= StIdle;
         rearm_q       <= 1'b0;
         hold_cnt_q    <= '0;
         tmo_cnt_q     <= '0;
         flush_cnt_q   <= '0;
         run_en_q      <= 1'b0;
         start_pulse_q <= 1'b0;
         stop_pulse_q  <= 1'b0;
         ts_rst_q      <= 1'b0;
         run_time_q    <= '0;
         run_count_q   <= '0;
         err_q         <= 1'b0;
      end else begin
         start_pulse_q <= 1'b0;
         ts_rst_q      <= 1'b0;
         stop_pulse_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // Rearm only from IDLE, so RUN held across FLUSH cannot restart.
               if (!run_bit) begin
                  rearm_q <= 1'b1;
               end else if (rearm_q) begin
                  rearm_q    <= 1'b0;
                  hold_cnt_q <= r_reg_q[HOLD_MSB:HOLD_LSB];
                  tmo_cnt_q  <= '0;
                  err_q      <= 1'b0;
                  state_q    <= r_reg_q[PPS_BIT] ? StWaitPps : StHoldoff;
               end
            end
            StWaitPps: begin
               if (!run_bit) begin
                  state_q <= StIdle;
               end else if (pps_rise) begin
                  state_q <= StHoldoff;
               end else if (tmo_cnt_q == TmoLast) begin
                  err_q   <= 1'b1;
                  state_q <= StIdle;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            StHoldoff: begin
               if (!run_bit) begin
                  state_q <= StIdle;
               end else if (hold_cnt_q == 16'd0) begin
                  state_q       <= StRun;
                  run_en_q      <= 1'b1;
                  start_pulse_q <= 1'b1;
                  ts_rst_q      <= 1'b1;
                  run_time_q    <= '0;
                  run_count_q   <= run_count_q + 16'd1;
               end else begin
                  hold_cnt_q <= hold_cnt_q - 16'd1;
               end
            end
            StRun: begin
               if (!run_bit) begin
                  state_q      <= StFlush;
                  run_en_q     <= 1'b0;
                  stop_pulse_q <= 1'b1;
                  flush_cnt_q  <= FlushLast;
               end else begin
                  run_time_q <= run_time_d;
               end
            end
            StFlush: begin
               if (flush_cnt_q == '0) begin
                  state_q <= StIdle;
               end else begin
                  flush_cnt_q <= flush_cnt_q - 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign run_en          = run_en_q;
   assign start_pulse     = start_pulse_q;
   assign stop_pulse      = stop_pulse_q;
   assign ts_rst          = ts_rst_q;
   assign run_time        = run_time_q;
   assign run_count       = run_count_q;
   assign state_out       = state_q;
   assign err_pps_timeout = err_q;

endmodule
